// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO result registers for the
// pipelined MIPS core. Sits beside the ALU in EX.
//
// mult/multu/div/divu run for a fixed number of cycles (MULT_CYCLES or
// DIV_CYCLES) while busy is high; mthi/mtlo write HI/LO in one cycle.
// The result is computed combinationally from operands latched at accept
// and written to HI/LO only on the last busy cycle. done pulses for one
// cycle after that write. cancel aborts an in-flight op without touching
// HI/LO, and also drops any request presented alongside it.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   request, accepted only when busy=0
//   op      in   [2:0] 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none
//   a       in   [WIDTH-1:0] rs operand (multiplicand/dividend/mthi-mtlo data)
//   b       in   [WIDTH-1:0] rt operand (multiplier/divisor)
//   cancel  in   abort in-flight operation
//   busy    out  multi-cycle operation in flight
//   done    out  one-cycle pulse after HI/LO commit
//   hi      out  [WIDTH-1:0] HI register
//   lo      out  [WIDTH-1:0] LO register
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0]        prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_by_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          safe_b;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quot_u;
  logic [WIDTH-1:0]          rem_u;

  // Result datapath, driven purely from the latched operands so that a new
  // request on a/b cannot disturb an operation already in flight.
  // Dividing by 1 instead of 0 keeps the divider well defined; the
  // divide-by-zero result is discarded at commit anyway. The same trick
  // covers most-negative / -1: dividing by 1 gives quotient = most-negative
  // and remainder 0, which is exactly the required non-trapping result.
  always_comb begin
    prod_s      = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                  $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u      = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_by_zero = (b_q == '0);
    div_ovf     = (op_q == OP_DIV) &&
                  (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    safe_b      = (div_by_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    quot_s      = $signed(a_q) / $signed(safe_b);
    rem_s       = $signed(a_q) % $signed(safe_b);
    quot_u      = a_q / safe_b;
    rem_u       = a_q % safe_b;
  end

  // Next-state logic. In IDLE a request is taken only without cancel; in
  // RUN cancel beats the final-cycle commit so an aborted op never lands.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op;
              count_d = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op;
              count_d = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (count_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!div_by_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OP_DIVU: begin
              if (!div_by_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // All state, including the done pulse, is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected HI/LO results are pushed to a queue when an operation is issued
// and popped when the unit leaves busy.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct {
    logic [31:0] hi_v;
    logic [31:0] lo_v;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        exp_q[$];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;
  int          checks;
  int          errors;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 64-bit arithmetic, so no special overflow case needed.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    e.hi_v = mdl_hi;
    e.lo_v = mdl_lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT: begin
        p = 64'(sx * sy);
        e.hi_v = p[63:32];
        e.lo_v = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        e.hi_v = p[63:32];
        e.lo_v = p[31:0];
      end
      OP_DIV: begin
        if (y != 0) begin
          q = sx / sy;
          r = sx % sy;
          e.lo_v = q[31:0];
          e.hi_v = r[31:0];
        end
      end
      OP_DIVU: begin
        if (y != 0) begin
          e.lo_v = x / y;
          e.hi_v = x % y;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Present one request for a single clock; called and returns on a negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    cancel = c;
    @(negedge clk);
    start  = 1'b0;
    op     = 3'd0;
    cancel = 1'b0;
  endtask

  // Count busy cycles until idle (bounded); report done at the idle cycle.
  task automatic wait_idle(output int n, output logic d);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    d = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL after_reset: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    mdl_hi = '0;
    mdl_lo = '0;
  endtask

  task automatic test_mult();
    exp_t e; int n; logic d;
    exp_q.push_back('{hi_v: 32'hFFFFFFFF, lo_v: 32'hFFFFFFFA});
    issue(OP_MULT, 32'hFFFFFFFE, 32'h3, 1'b0);
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL mult_busy_len: got %0d want 5", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL mult_done: got %b want 1", d); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL mult_result: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_width: got %b want 0", done); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_multu();
    exp_t e; int n; logic d;
    exp_q.push_back('{hi_v: 32'h00000002, lo_v: 32'hFFFFFFFA});
    issue(OP_MULTU, 32'hFFFFFFFE, 32'h3, 1'b0);
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL multu_busy_len: got %0d want 5", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL multu_done: got %b want 1", d); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL multu_result: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_div();
    exp_t e; int n; logic d;
    exp_q.push_back('{hi_v: 32'hFFFFFFFF, lo_v: 32'hFFFFFFFD});
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    checks++;
    if ({hi, lo} !== {mdl_hi, mdl_lo}) begin
      errors++;
      $display("[TB] FAIL div_hold_during_run: got %h_%h want %h_%h", hi, lo, mdl_hi, mdl_lo);
    end
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL div_busy_len: got %0d want 10", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL div_done: got %b want 1", d); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL div_result: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_divu();
    exp_t e; int n; logic d;
    exp_q.push_back('{hi_v: 32'h00000001, lo_v: 32'h7FFFFFFC});
    issue(OP_DIVU, 32'hFFFFFFF9, 32'h2, 1'b0);
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL divu_busy_len: got %0d want 10", n); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL divu_result: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0);
    checks++;
    if (hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mthi: got hi=%h busy=%b done=%b want hi=deadbeef busy=0 done=0", hi, busy, done);
    end
    mdl_hi = 32'hDEADBEEF;
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0, 1'b0);
    checks++;
    if (lo !== 32'hCAFEF00D || hi !== mdl_hi || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo: got hi=%h lo=%h busy=%b want hi=%h lo=cafef00d busy=0", hi, lo, busy, mdl_hi);
    end
    mdl_lo = 32'hCAFEF00D;
    issue(3'd7, 32'h55555555, 32'h1, 1'b0);
    checks++;
    if ({hi, lo} !== {mdl_hi, mdl_lo} || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reserved_op: got hi=%h lo=%h busy=%b want %h_%h busy=0", hi, lo, busy, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_div_zero();
    exp_t e; int n; logic d;
    issue(OP_MTHI, 32'h11, 32'h0, 1'b0);
    issue(OP_MTLO, 32'h22, 32'h0, 1'b0);
    mdl_hi = 32'h11; mdl_lo = 32'h22;
    exp_q.push_back('{hi_v: 32'h11, lo_v: 32'h22});
    issue(OP_DIV, 32'h1234, 32'h0, 1'b0);
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL divzero_busy_len: got %0d want 10", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL divzero_done: got %b want 1", d); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL divzero_unchanged: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
  endtask

  task automatic test_div_overflow();
    exp_t e; int n; logic d;
    exp_q.push_back('{hi_v: 32'h0, lo_v: 32'h80000000});
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL div_overflow: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_cancel();
    int hits;
    // Cancel on the third RUN cycle.
    issue(OP_MULT, 32'h7, 32'h9, 1'b0);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== {mdl_hi, mdl_lo}) begin
      errors++;
      $display("[TB] FAIL cancel_mid: got busy=%b hi=%h lo=%h want busy=0 %h_%h", busy, hi, lo, mdl_hi, mdl_lo);
    end
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) hits++;
      @(negedge clk);
    end
    checks++; if (hits != 0) begin errors++; $display("[TB] FAIL cancel_no_done: got %0d done pulses want 0", hits); end
    // Cancel on the final RUN cycle: no commit, no done.
    issue(OP_MULT, 32'h7, 32'h9, 1'b0);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== {mdl_hi, mdl_lo}) begin
      errors++;
      $display("[TB] FAIL cancel_last: got busy=%b done=%b hi=%h lo=%h want 0 0 %h_%h", busy, done, hi, lo, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_cancel_with_start();
    issue(OP_MTHI, 32'h12345678, 32'h0, 1'b1);
    checks++;
    if (hi !== mdl_hi) begin errors++; $display("[TB] FAIL cancel_mthi: got hi=%h want %h", hi, mdl_hi); end
    issue(OP_DIV, 32'h100, 32'h3, 1'b1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_start_div: got busy=%b want 0", busy); end
  endtask

  task automatic test_start_while_busy();
    exp_t e; int n; logic d;
    exp_q.push_back(model(OP_DIV, 32'd100, 32'd7));
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n, d);
    e = exp_q.pop_front();
    checks++; if (n + 2 != 10) begin errors++; $display("[TB] FAIL busy_start_len: got %0d want 10", n + 2); end
    checks++; if ({hi, lo} !== {e.hi_v, e.lo_v}) begin errors++; $display("[TB] FAIL busy_start_result: got %h_%h want %h_%h", hi, lo, e.hi_v, e.lo_v); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_relaunch: got busy=%b want 0", busy); end
    mdl_hi = e.hi_v; mdl_lo = e.lo_v;
  endtask

  task automatic test_back_to_back();
    exp_t e; int n; logic d;
    logic [2:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = (i == 3) ? 32'd0 : ((i == 5) ? 32'hFFFFFFFF : $urandom);
      e = model(o, x, y);
      exp_q.push_back(e);
      mdl_hi = e.hi_v; mdl_lo = e.lo_v;
      issue(o, x, y, 1'b0);
      wait_idle(n, d);
      e = exp_q.pop_front();
      checks++;
      if (n != ((o <= OP_MULTU) ? 5 : 10) || d !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_timing op=%0d: got busy=%0d done=%b", o, n, d);
      end
      checks++;
      if ({hi, lo} !== {e.hi_v, e.lo_v}) begin
        errors++;
        $display("[TB] FAIL b2b_result op=%0d a=%h b=%h: got %h_%h want %h_%h", o, x, y, hi, lo, e.hi_v, e.lo_v);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int hits;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || busy === 1'b1) hits++;
      @(negedge clk);
    end
    checks++; if (hits != 0) begin errors++; $display("[TB] FAIL reset_mid_op_quiet: got %0d busy/done cycles want 0", hits); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_mthi_mtlo();
    test_div_zero();
    test_div_overflow();
    test_cancel();
    test_cancel_with_start();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Sits beside the ALU in the EX stage. Executes mult, multu, div, divu over a configurable number of cycles, and mthi/mtlo in a single cycle.
- Exposes busy so the hazard unit can stall any later md_unit instruction or mfhi/mflo.
- Supports cancellation of an in-flight operation on exception or flush.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; operation accepted only when busy=0.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  WIDTH  operand rs; multiplicand, dividend, or mthi/mtlo data.
- b  input  WIDTH  operand rt; multiplier or divisor.
- cancel  input  1  abort the in-flight operation; HI/LO keep their values.
- busy  output  1  high while a multi-cycle operation is in flight.
- done  output  1  one-cycle pulse on the cycle after HI/LO are committed.
- hi  output  WIDTH  HI register (registered; used by mfhi).
- lo  output  WIDTH  LO register (registered; used by mflo).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - Counter, operand latches and FSM return to IDLE.
- FSM states: IDLE and RUN.
- IDLE, start=1, op in 1..4, cancel=0:
  - Latch a, b and op at the edge; go to RUN.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- IDLE, start=1, op=5 or 6, cancel=0:
  - Write a into hi (op 5) or lo (op 6) at the edge.
  - busy stays 0; done is not asserted.
- IDLE, start=1, op 0 or 7: no effect.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 1 (the last busy cycle):
    - Commit the result to hi/lo.
    - Return to IDLE; busy=0 on the next cycle.
    - done=1 for exactly that next cycle.
  - busy is therefore high for exactly N consecutive cycles after the accept cycle.
- start while busy=1: ignored, and operands are not re-latched. Stalling the requester is the hazard unit's job.
- cancel:
  - In RUN: return to IDLE at the edge; busy=0 next cycle; no commit; no done pulse.
  - Asserted with start while IDLE: cancel wins; the request (including mthi/mtlo) is dropped.
  - In the final RUN cycle: the cancel wins and no commit occurs.
- Arithmetic, using the operands latched at accept:
  - mult: {hi,lo} = signed a x signed b, full 2*WIDTH-bit product.
  - multu: same as mult, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient to lo, remainder to hi.
  - div with a = most-negative and b = -1: lo = most-negative value, hi = 0; no trap.
  - Division by zero (div or divu):
    - hi/lo unchanged.
    - busy still lasts DIV_CYCLES and done still pulses.
- Results may be computed combinationally from the latched operands and registered at the commit edge. hi/lo must not change before the commit edge.
- hi/lo are stable and readable during RUN, holding the previous values. Forwarding is handled outside this block.

Test Plan:
- Reset mid-operation: assert reset during RUN of a div -> hi=lo=0, busy=0 immediately (asynchronous); no done afterwards.
- mult, WIDTH=32: a=0xFFFFFFFE (-2), b=0x00000003 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div: a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu: a=0xFFFFFFF9, b=2 -> lo=0x7FFFFFFC, hi=1.
- Divide by zero: hi=0x11, lo=0x22, then div with b=0 -> busy 10 cycles, done pulses, hi=0x11 and lo=0x22 unchanged.
- Overflow: a=0x80000000, b=0xFFFFFFFF, signed div -> lo=0x80000000, hi=0.
- mthi/mtlo and cancel:
  - mthi a=0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy stays 0.
  - start mult, then cancel on cycle 3 of RUN -> busy=0 next cycle, hi/lo unchanged, no done.
  - start mthi with cancel=1 in the same cycle -> no write.
  - start div while busy -> ignored; the original op's result commits.
